// File: rtl/controller_mc.sv
// Multicycle control unit for the ARM core: sequences fetch/decode/execute/
// memory/writeback, owns the NZCV flags register, evaluates the condition
// field and drives every datapath enable and mux select.
module controller_mc (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         AdrSrc,
  output logic         MemWrite,
  output logic         IRWrite,
  output logic         RegWrite,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ImmSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [2:0]   ALUControl,
  output logic [1:0]   ResultSrc,
  output logic         InstrDone
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];

  logic [3:0] state_q, state_d;
  logic [3:0] flags_q;            // {N,Z,C,V}
  logic       flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  logic       cond_ok;
  logic [2:0] cmd_alu_ctrl;
  logic       cmd_reg_wr;
  logic       cmd_flag_all;
  logic       cmd_flag_nz;
  logic       in_execute;
  logic       pc_write_raw, mem_write_raw, reg_write_raw;

  assign in_execute = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);

  // Condition field evaluated against the committed flags register
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first so no path can leave it unassigned and infer a latch.
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = flag_z;
      4'h1: cond_ok = !flag_z;
      4'h2: cond_ok = flag_c;
      4'h3: cond_ok = !flag_c;
      4'h4: cond_ok = flag_n;
      4'h5: cond_ok = !flag_n;
      4'h6: cond_ok = flag_v;
      4'h7: cond_ok = !flag_v;
      4'h8: cond_ok = flag_c && !flag_z;
      4'h9: cond_ok = !flag_c || flag_z;
      4'hA: cond_ok = (flag_n == flag_v);
      4'hB: cond_ok = (flag_n != flag_v);
      4'hC: cond_ok = !flag_z && (flag_n == flag_v);
      4'hD: cond_ok = flag_z || (flag_n != flag_v);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Data-processing command decode: ALU op, register write and flag-write class
  always_comb begin
    cmd_alu_ctrl = 3'b000;
    cmd_reg_wr   = 1'b0;
    cmd_flag_all = 1'b0;
    cmd_flag_nz  = 1'b0;
    case (funct[4:1])
      4'b0100: begin cmd_alu_ctrl = 3'b000; cmd_reg_wr = 1'b1; cmd_flag_all = funct[0]; end
      4'b0010: begin cmd_alu_ctrl = 3'b001; cmd_reg_wr = 1'b1; cmd_flag_all = funct[0]; end
      4'b0000: begin cmd_alu_ctrl = 3'b010; cmd_reg_wr = 1'b1; cmd_flag_nz  = funct[0]; end
      4'b1100: begin cmd_alu_ctrl = 3'b011; cmd_reg_wr = 1'b1; cmd_flag_nz  = funct[0]; end
      4'b1010: begin cmd_alu_ctrl = 3'b001; cmd_flag_all = 1'b1; end
      default: ;
    endcase
  end

  // Next-state logic and per-state control outputs
  always_comb begin
    state_d       = state_q;
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    RegSrc        = 2'b00;
    ImmSrc        = op;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUControl    = 3'b000;
    ResultSrc     = 2'b00;
    InstrDone     = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite      = 1'b1;
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        pc_write_raw = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (!cond_ok || op == 2'b11) begin
          InstrDone = 1'b1;
          state_d   = S_FETCH;
        end else if (op == 2'b01) begin
          state_d = S_MEMADR;
        end else if (op == 2'b10) begin
          state_d = S_BRANCH;
        end else begin
          state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
        end
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        pc_write_raw  = (rd == 4'd15);
        InstrDone     = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        RegSrc        = 2'b10;
        InstrDone     = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcB    = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = cmd_alu_ctrl;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = cmd_reg_wr;
        pc_write_raw  = cmd_reg_wr && (rd == 4'd15);
        InstrDone     = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        RegSrc       = 2'b01;
        ALUSrcB      = 2'b01;
        ResultSrc    = 2'b10;
        pc_write_raw = 1'b1;
        InstrDone    = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are suppressed while reset is asserted, except that the
  // FETCH-state PC/IR enables follow state alone.
  assign PCWrite  = pc_write_raw && (!reset || state_q == S_FETCH);
  assign MemWrite = mem_write_raw && !reset;
  assign RegWrite = reg_write_raw && !reset;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values regardless of block order.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Flags register: written only in the execute states
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (in_execute) begin
      if (cmd_flag_all)     flags_q      <= ALUFlags;
      else if (cmd_flag_nz) flags_q[3:2] <= ALUFlags[3:2];
    end
  end

endmodule

// File: tb/tb_controller_mc.sv
// Scoreboard bench for controller_mc: the stimulus process drives one cycle
// at a time and queues the expected output vector; a monitor pops and
// compares on every falling edge.
module tb_controller_mc;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, InstrDone;
  logic [1:0]   RegSrc, ImmSrc, ALUSrcB, ResultSrc;
  logic [2:0]   ALUControl;

  always #5 clk = ~clk;

  controller_mc dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegSrc     (RegSrc),
    .ImmSrc     (ImmSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ResultSrc  (ResultSrc),
    .InstrDone  (InstrDone)
  );

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] regsrc, immsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [1:0] ressrc;
    logic       done;
  } exp_t;

  typedef struct {
    logic [17:0] e;
    logic [17:0] m;
    string       name;
  } item_t;

  item_t       sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [17:0] act_v;
  logic [17:0] all_m;
  logic [17:0] wr_m;
  logic [3:0]  idle_fl = 4'hF;  // ALUFlags outside execute must never reach the flags register

  assign act_v = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ResultSrc, InstrDone};

  // Expected vectors per control state
  function automatic exp_t e_base(input logic [1:0] op);
    exp_t e = '0;
    e.immsrc = op;
    return e;
  endfunction
  function automatic exp_t e_fetch(input logic [1:0] op);
    exp_t e = e_base(op);
    e.pcw = 1'b1; e.irw = 1'b1; e.srca = 1'b1; e.srcb = 2'b10; e.ressrc = 2'b10;
    return e;
  endfunction
  function automatic exp_t e_decode(input logic [1:0] op, input logic done);
    exp_t e = e_base(op);
    e.srca = 1'b1; e.srcb = 2'b10; e.ressrc = 2'b10; e.done = done;
    return e;
  endfunction
  function automatic exp_t e_exec(input logic imm, input logic [2:0] aluc);
    exp_t e = e_base(2'b00);
    e.srcb = imm ? 2'b01 : 2'b00; e.aluc = aluc;
    return e;
  endfunction
  function automatic exp_t e_aluwb(input logic regw, input logic pcw);
    exp_t e = e_base(2'b00);
    e.regw = regw; e.pcw = pcw; e.done = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_memadr();
    exp_t e = e_base(2'b01);
    e.srcb = 2'b01;
    return e;
  endfunction
  function automatic exp_t e_memread();
    exp_t e = e_base(2'b01);
    e.adr = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_memwb(input logic pcw);
    exp_t e = e_base(2'b01);
    e.ressrc = 2'b01; e.regw = 1'b1; e.pcw = pcw; e.done = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_memwrite();
    exp_t e = e_base(2'b01);
    e.adr = 1'b1; e.memw = 1'b1; e.regsrc = 2'b10; e.done = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_branch();
    exp_t e = e_base(2'b10);
    e.regsrc = 2'b01; e.srcb = 2'b01; e.ressrc = 2'b10; e.pcw = 1'b1; e.done = 1'b1;
    return e;
  endfunction

  // One stimulus cycle: drive inputs, queue the expectation, advance past the edge
  task automatic cyc(input logic [31:0] ins, input logic [3:0] fl, input logic rst,
                     input exp_t e, input logic [17:0] m, input string nm);
    item_t it;
    Instr    = ins[31:12];
    ALUFlags = fl;
    reset    = rst;
    it.e = e; it.m = m; it.name = nm;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic run_dp(input logic [31:0] ins, input logic [3:0] fl, input logic imm,
                        input logic [2:0] aluc, input logic regw, input logic pcw, input string nm);
    cyc(ins, idle_fl, 1'b0, e_fetch(2'b00), all_m, {nm, "_fetch"});
    cyc(ins, idle_fl, 1'b0, e_decode(2'b00, 1'b0), all_m, {nm, "_decode"});
    cyc(ins, fl, 1'b0, e_exec(imm, aluc), all_m, {nm, "_exec"});
    cyc(ins, idle_fl, 1'b0, e_aluwb(regw, pcw), all_m, {nm, "_aluwb"});
  endtask

  task automatic run_skip(input logic [31:0] ins, input string nm);
    cyc(ins, idle_fl, 1'b0, e_fetch(ins[27:26]), all_m, {nm, "_fetch"});
    cyc(ins, idle_fl, 1'b0, e_decode(ins[27:26], 1'b1), all_m, {nm, "_decode_exit"});
  endtask

  task automatic run_b(input logic [31:0] ins, input string nm);
    cyc(ins, idle_fl, 1'b0, e_fetch(2'b10), all_m, {nm, "_fetch"});
    cyc(ins, idle_fl, 1'b0, e_decode(2'b10, 1'b0), all_m, {nm, "_decode"});
    cyc(ins, idle_fl, 1'b0, e_branch(), all_m, {nm, "_branch"});
  endtask

  task automatic run_ldr(input logic [31:0] ins, input logic pcw, input string nm);
    cyc(ins, idle_fl, 1'b0, e_fetch(2'b01), all_m, {nm, "_fetch"});
    cyc(ins, idle_fl, 1'b0, e_decode(2'b01, 1'b0), all_m, {nm, "_decode"});
    cyc(ins, idle_fl, 1'b0, e_memadr(), all_m, {nm, "_memadr"});
    cyc(ins, idle_fl, 1'b0, e_memread(), all_m, {nm, "_memread"});
    cyc(ins, idle_fl, 1'b0, e_memwb(pcw), all_m, {nm, "_memwb"});
  endtask

  // Monitor: outputs are combinational, so one expected vector per cycle
  always @(negedge clk) begin
    item_t it;
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      checks++;
      if ((act_v & it.m) !== (it.e & it.m)) begin
        failures++;
        $display("FAIL %s: got %h expected %h (mask %h)", it.name, act_v, it.e, it.m);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t wm;
    exp_t zero_e;
    all_m = '1;
    wm = '0; wm.memw = 1'b1; wm.regw = 1'b1;
    wr_m = wm;
    zero_e = '0;

    // Reset held 3 cycles; state is FETCH from the first edge on
    reset = 1'b1; Instr = '0; ALUFlags = 4'h0;
    @(posedge clk); #1;
    cyc(32'h0, 4'h0, 1'b1, e_fetch(2'b00), all_m, "rst_hold1");
    cyc(32'h0, 4'h0, 1'b1, e_fetch(2'b00), all_m, "rst_hold2");

    // ADD R1,R2,R3 (S=0): flags stay 0000 despite ALUFlags=1111
    run_dp(32'hE0821003, 4'hF, 1'b0, 3'b000, 1'b1, 1'b0, "add");
    run_skip(32'h0A000002, "beq_z0");              // Z=0: not taken
    // CMP R0,#0 with ALUFlags=0100 -> flags 0100
    run_dp(32'hE1500000, 4'b0100, 1'b0, 3'b001, 1'b0, 1'b0, "cmp");
    run_b(32'h0A000002, "beq_taken");
    run_skip(32'h1A000002, "bne_z1");
    // Loads and store
    run_ldr(32'hE5912004, 1'b0, "ldr_r2");
    run_ldr(32'hE591F004, 1'b1, "ldr_pc");
    cyc(32'hE5812004, idle_fl, 1'b0, e_fetch(2'b01), all_m, "str_fetch");
    cyc(32'hE5812004, idle_fl, 1'b0, e_decode(2'b01, 1'b0), all_m, "str_decode");
    cyc(32'hE5812004, idle_fl, 1'b0, e_memadr(), all_m, "str_memadr");
    cyc(32'hE5812004, idle_fl, 1'b0, e_memwrite(), all_m, "str_memwrite");
    // Flags 1111, then ORRS PC,R1,#1 with ALUFlags 0000 -> NZ cleared, CV held: 0011
    run_dp(32'hE1500000, 4'hF, 1'b0, 3'b001, 1'b0, 1'b0, "cmp_f");
    run_dp(32'hE391F001, 4'h0, 1'b1, 3'b011, 1'b1, 1'b1, "orrs_pc");
    // Unsupported command (EOR, S=1): no register or flag write
    run_dp(32'hE0321003, 4'b0100, 1'b0, 3'b000, 1'b0, 1'b0, "eors");
    run_skip(32'h0A000002, "beq_after_orr");       // Z=0
    run_b(32'h2A000000, "bcs_taken");              // C=1
    run_b(32'h6A000000, "bvs_taken");              // V=1
    run_skip(32'h4A000000, "bmi_n0");              // N=0
    run_skip(32'hAA000000, "bge_false");           // N!=V
    run_b(32'hBA000000, "blt_taken");              // N!=V
    run_skip(32'hEC000000, "op11");
    run_skip(32'hF0821003, "cond_nv");
    // ANDS R1,R1,R3 with ALUFlags 1000 -> flags 1011
    run_dp(32'hE0111003, 4'b1000, 1'b0, 3'b010, 1'b1, 1'b0, "ands");
    run_b(32'h4A000000, "bmi_taken");              // N=1
    run_skip(32'h7A000000, "bvc_false");           // V held at 1
    run_b(32'h8A000000, "bhi_taken");              // C=1,Z=0

    // Reset mid-instruction: flags 1111, reset asserted during MEMREAD
    run_dp(32'hE1500000, 4'hF, 1'b0, 3'b001, 1'b0, 1'b0, "cmp_ones");
    cyc(32'hE5912004, idle_fl, 1'b0, e_fetch(2'b01), all_m, "rst_ldr_fetch");
    cyc(32'hE5912004, idle_fl, 1'b0, e_decode(2'b01, 1'b0), all_m, "rst_ldr_decode");
    cyc(32'hE5912004, idle_fl, 1'b0, e_memadr(), all_m, "rst_ldr_memadr");
    cyc(32'hE5912004, idle_fl, 1'b1, e_memread(), all_m, "rst_ldr_memread");
    run_skip(32'h0A000002, "beq_after_rst");       // flags 0000: Z=0
    run_b(32'h5A000000, "bpl_after_rst");          // N=0
    // Reset during MEMWRITE: the store must not be written
    cyc(32'hE5812004, idle_fl, 1'b0, e_fetch(2'b01), all_m, "rst_str_fetch");
    cyc(32'hE5812004, idle_fl, 1'b0, e_decode(2'b01, 1'b0), all_m, "rst_str_decode");
    cyc(32'hE5812004, idle_fl, 1'b0, e_memadr(), all_m, "rst_str_memadr");
    cyc(32'hE5812004, idle_fl, 1'b1, zero_e, wr_m, "rst_str_memwrite_gated");
    run_dp(32'hE0821003, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0, "add_after_rst");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controller_mc.md
# controller_mc

Multicycle control unit for the ARM core. It sequences a shared-ALU, single-memory datapath through fetch, decode, execute, memory and writeback states. It owns the NZCV condition-flag register and evaluates the instruction condition field. It drives every datapath enable and mux select each cycle, and exports `ALUControl` and `RegWrite` for the `led_controller` status path.

## Interface
Parameters: none.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Instr` in 20: `Instr[31:12]` from the instruction register. Fields used:
  - Cond `[31:28]`, Op `[27:26]`, Funct `[25:20]`, Rd `[15:12]`.
- `ALUFlags` in 4: live ALU flags {N,Z,C,V}.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction register enable.
- `RegWrite` out 1: register file write enable.
- `RegSrc` out 2: bit 0 = read PC as Rn (branch); bit 1 = read Rd as src2 (STR).
- `ImmSrc` out 2: extend mode. Equals Op in all states.
- `ALUSrcA` out 1: 0 = register A, 1 = PC.
- `ALUSrcB` out 2: 00 = register, 01 = ExtImm, 10 = constant 4.
- `ALUControl` out 3: 000 ADD, 001 SUB, 010 AND, 011 ORR.
- `ResultSrc` out 2: 00 = ALUOut, 01 = read data, 10 = ALUResult.
- `InstrDone` out 1: one-cycle pulse on the final state of every instruction.

## Operation
- **State register:** resets to FETCH.
- **Flags register:** 4 bits, resets to 0000.
- **FETCH:**
  - Outputs: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1.
  - Next: DECODE.
- **DECODE:**
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUControl=000, ResultSrc=10. This computes PC+8.
  - Condition false, or Op=11: next is FETCH and InstrDone=1.
  - Op=01 (memory): next is MEMADR.
  - Op=10 (branch): next is BRANCH.
  - Op=00 (data processing): next is EXECUTEI when Funct[5]=1, else EXECUTER.
- **MEMADR:**
  - Outputs: ALUSrcA=0, ALUSrcB=01, ALUControl=000.
  - Next: MEMREAD when Funct[0]=1 (LDR), else MEMWRITE.
- **MEMREAD:** AdrSrc=1, ResultSrc=00. Next: MEMWB.
- **MEMWB:**
  - Outputs: ResultSrc=01, RegWrite=1, InstrDone=1. PCWrite=1 if Rd=15.
  - Next: FETCH.
- **MEMWRITE:** AdrSrc=1, MemWrite=1, RegSrc[1]=1, InstrDone=1. Next: FETCH.
- **EXECUTER / EXECUTEI:**
  - Outputs: ALUSrcA=0, ALUSrcB=00 or 01, ALUControl decoded from Funct[4:1].
  - Next: ALUWB.
- **ALUWB:**
  - Outputs: ResultSrc=00, InstrDone=1.
  - RegWrite=1 unless the command is CMP or unsupported. PCWrite=1 if Rd=15 and RegWrite.
  - Next: FETCH.
- **BRANCH:**
  - Outputs: RegSrc[0]=1, ALUSrcA=0, ALUSrcB=01, ALUControl=000, ResultSrc=10, PCWrite=1, InstrDone=1.
  - Next: FETCH.
- **Command decode (Funct[4:1]):**
  - 0100 ADD → 000.
  - 0010 SUB → 001.
  - 0000 AND → 010.
  - 1100 ORR → 011.
  - 1010 CMP → 001, with forced flag write and no register write.
  - Any other value → 000, with no register or flag write.
- **Flag writes:** only in EXECUTER or EXECUTEI.
  - ADD/SUB with S=1, and CMP: load all NZCV from ALUFlags.
  - AND/ORR with S=1: load N and Z only; C and V are held.
- **Condition evaluation:** combinational, in DECODE only, against the flags register. Because a failing condition exits at DECODE, later states need no condition gating.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 evaluates to 0.
- **Defaults:** every output not listed for a state is 0.

## Timing
- All outputs are combinational from state, Instr and the flags register (Moore plus decode). There are no output registers.
- **Cycles per instruction:**
  - Condition-fail or Op=11: 2.
  - B: 3.
  - STR: 4.
  - Data processing: 4.
  - LDR: 5.
- **Flags visibility:** the flags register updates at the end of the EXECUTE cycle. The next instruction's DECODE sees the new value.
- **Reset mid-instruction:** reset in any state → FETCH and flags=0000 on the next edge. No write enable is asserted in the reset cycle.
- **Reset during FETCH:** PCWrite and IRWrite still follow state combinationally; reset does not gate them.
- `InstrDone` is high for exactly one cycle per instruction and is never high in FETCH.

## Test plan
- **Reset release:** hold reset 3 cycles, then release. First cycle shows FETCH with PCWrite=1, IRWrite=1, ALUSrcB=10, MemWrite=0, RegWrite=0.
- **Data-processing sequence:** 0xE0821003 (ADD R1,R2,R3).
  - States: FETCH, DECODE, EXECUTER, ALUWB.
  - ALUControl=000 in EXECUTER.
  - RegWrite=1 and InstrDone=1 only in ALUWB. PCWrite=0 in ALUWB.
- **Flag write then taken branch:** 0xE1500000 (CMP) with ALUFlags=0100 during EXECUTER.
  - Flags become 0100. RegWrite is never asserted.
  - Then 0x0A000002 (BEQ) reaches BRANCH with PCWrite=1 and RegSrc[0]=1.
- **Not-taken branch:** with Z=1, 0x1A000002 (BNE).
  - States: FETCH, DECODE (InstrDone=1), FETCH.
  - No PCWrite in DECODE.
- **Load sequence:** 0xE5912004 (LDR).
  - States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - AdrSrc=1 in MEMREAD. ResultSrc=01 and RegWrite=1 in MEMWB.
  - Repeat with Rd=15 (0xE591F004): PCWrite=1 in MEMWB.
- **Reset mid-operation:** flags preset to 1111. Assert reset in MEMREAD.
  - Next cycle: FETCH, flags=0000.
  - MemWrite and RegWrite stay 0 throughout.
